fetch_stage: RTL

- Instruction fetch stage between the program counter and decode.
- Consumes the counter's current PC, issues a synchronous instruction-memory read, and presents {pc, instr} to decode over a valid/ready handshake.
- Drives the counter's active-low load port back to it, so it can redirect the counter on taken branches and freeze it under decode backpressure. The counter otherwise increments every clock.

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 75 +++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bundle: counter feedback, instruction memory port, decode handshake
interface fetch_stage_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]  pc;
    logic                   pc_ld;
    logic [DATA_WIDTH-1:0]  pc_in;
    logic [DATA_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   br_taken;
    logic [DATA_WIDTH-1:0]  br_target;
    logic                   id_valid;
    logic                   id_ready;
    logic [DATA_WIDTH-1:0]  id_pc;
    logic [INSTR_WIDTH-1:0] id_instr;

    modport master (
        input  pc, imem_rdata, br_taken, br_target, id_ready,
        output pc_ld, pc_in, imem_addr, id_valid, id_pc, id_instr
    );

    modport slave (
        output pc, imem_rdata, br_taken, br_target, id_ready,
        input  pc_ld, pc_in, imem_addr, id_valid, id_pc, id_instr
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with one-deep memory pipeline, skid entry and branch flush
module fetch_stage #(
    parameter int DATA_WIDTH  = 8,
    parameter int INSTR_WIDTH = 16
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);
    logic                   s1_valid;
    logic [DATA_WIDTH-1:0]  s1_pc;
    logic                   sk_valid;
    logic [DATA_WIDTH-1:0]  sk_pc;
    logic [INSTR_WIDTH-1:0] sk_instr;
    logic                   hold;
    logic                   issue;

    assign hold          = bus.id_valid & ~bus.id_ready;
    assign bus.imem_addr = bus.pc;

    // Redirect beats stall; a stall freezes the counter on the address not yet issued.
    always_comb begin
        bus.pc_ld = 1'b1;
        bus.pc_in = bus.pc;
        issue     = 1'b0;
        if (bus.br_taken) begin
            bus.pc_ld = 1'b0;
            bus.pc_in = bus.br_target;
        end else if (hold) begin
            bus.pc_ld = 1'b0;
        end else begin
            issue = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid     <= 1'b0;
            s1_pc        <= '0;
            sk_valid     <= 1'b0;
            sk_pc        <= '0;
            sk_instr     <= '0;
            bus.id_valid <= 1'b0;
            bus.id_pc    <= '0;
            bus.id_instr <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_pc <= bus.pc;
            end
            if (bus.br_taken) begin
                bus.id_valid <= 1'b0;
                sk_valid     <= 1'b0;
            end else if (!hold) begin
                if (sk_valid) begin
                    bus.id_valid <= 1'b1;
                    bus.id_pc    <= sk_pc;
                    bus.id_instr <= sk_instr;
                    sk_valid     <= 1'b0;
                end else if (s1_valid) begin
                    bus.id_valid <= 1'b1;
                    bus.id_pc    <= s1_pc;
                    bus.id_instr <= bus.imem_rdata;
                end else begin
                    bus.id_valid <= 1'b0;
                end
            end else if (s1_valid) begin
                // Memory data is only on the bus for this one cycle, so park it.
                sk_valid <= 1'b1;
                sk_pc    <= s1_pc;
                sk_instr <= bus.imem_rdata;
            end
        end
    end
endmodule
